// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard unit: load-use/branch/memory-wait stalls, flushes and operand forwarding
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic        MemAccessM,
    input  logic        mem_ready,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        mem_err,
    output logic [31:0] stall_cnt
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0] TMO = TIMEOUT[7:0];

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wcnt;
    logic [7:0] wcnt_nxt;
    logic       err_nxt;
    logic       mem_stall_raw;
    logic       lw_stall_raw;
    logic       mem_stall;
    logic       lw_stall;

    always_comb begin
        state_nxt     = state;
        wcnt_nxt      = wcnt;
        err_nxt       = 1'b0;
        mem_stall_raw = 1'b0;
        case (state)
            IDLE: begin
                if (MemAccessM && !mem_ready) begin
                    state_nxt     = WAIT;
                    wcnt_nxt      = 8'd1;
                    mem_stall_raw = 1'b1;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                end else if (wcnt == TMO) begin
                    // Give up on the access; the stall releases this cycle, error pulses next.
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    wcnt_nxt      = wcnt + 8'd1;
                    mem_stall_raw = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign lw_stall_raw = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                          ((RdE == Rs1D) || (RdE == Rs2D));

    // Hazard outputs are forced quiet while reset is held.
    assign mem_stall = mem_stall_raw && !rst;
    assign lw_stall  = lw_stall_raw && !rst;

    assign StallF = lw_stall || mem_stall;
    assign StallD = lw_stall || mem_stall;
    assign StallE = mem_stall;
    assign StallM = mem_stall;
    assign FlushD = PCSrcE && !rst && !mem_stall;
    assign FlushE = (lw_stall || (PCSrcE && !rst)) && !mem_stall;
    assign FlushW = mem_stall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
            return 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E);
    assign ForwardBE = fwd_sel(Rs2E);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wcnt      <= 8'd0;
            mem_err   <= 1'b0;
            stall_cnt <= 32'd0;
        end else begin
            state   <= state_nxt;
            wcnt    <= wcnt_nxt;
            mem_err <= err_nxt;
            if (StallF && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl (default and TIMEOUT=3 instances)
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, MemAccessM, mem_ready;

    logic [1:0]  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, merr;
    logic [3:0]  fae_p, fbe_p;
    logic [63:0] cnt_p;

    int n_vec  = 0;
    int n_fail = 0;

    int          k   [2];
    bit          err [2];
    logic [31:0] cnt [2];
    int          tmo [2];

    always #5 clk = ~clk;

    hazard_ctrl dut_a (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM), .mem_ready(mem_ready),
        .StallF(stall_f[0]), .StallD(stall_d[0]), .StallE(stall_e[0]), .StallM(stall_m[0]),
        .FlushD(flush_d[0]), .FlushE(flush_e[0]), .FlushW(flush_w[0]),
        .ForwardAE(fae_p[1:0]), .ForwardBE(fbe_p[1:0]), .mem_err(merr[0]), .stall_cnt(cnt_p[31:0])
    );

    hazard_ctrl #(.TIMEOUT(3)) dut_b (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM), .mem_ready(mem_ready),
        .StallF(stall_f[1]), .StallD(stall_d[1]), .StallE(stall_e[1]), .StallM(stall_m[1]),
        .FlushD(flush_d[1]), .FlushE(flush_e[1]), .FlushW(flush_w[1]),
        .ForwardAE(fae_p[3:2]), .ForwardBE(fbe_p[3:2]), .mem_err(merr[1]), .stall_cnt(cnt_p[63:32])
    );

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww;
        logic [1:0] rsrc;
        logic       pc;
        logic       x_stall, x_fd, x_fe;
        logic [1:0] x_fae, x_fbe;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Sample at the falling edge and compare every output of both instances with the model.
    task automatic tick_check();
        logic lw, ms;
        @(negedge clk);
        lw = !rst && ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        for (int i = 0; i < 2; i++) begin
            ms = !rst && !mem_ready && ((k[i] == 0) ? MemAccessM : (k[i] < tmo[i]));
            chk($sformatf("StallF[%0d]", i), 32'(stall_f[i]), 32'(lw | ms));
            chk($sformatf("StallD[%0d]", i), 32'(stall_d[i]), 32'(lw | ms));
            chk($sformatf("StallE[%0d]", i), 32'(stall_e[i]), 32'(ms));
            chk($sformatf("StallM[%0d]", i), 32'(stall_m[i]), 32'(ms));
            chk($sformatf("FlushD[%0d]", i), 32'(flush_d[i]), 32'(!rst && PCSrcE && !ms));
            chk($sformatf("FlushE[%0d]", i), 32'(flush_e[i]), 32'((lw || (!rst && PCSrcE)) && !ms));
            chk($sformatf("FlushW[%0d]", i), 32'(flush_w[i]), 32'(ms));
            chk($sformatf("mem_err[%0d]", i), 32'(merr[i]), 32'(err[i]));
            chk($sformatf("stall_cnt[%0d]", i), cnt_p[32*i +: 32], cnt[i]);
        end
        chk("ForwardAE", 32'(fae_p[1:0]), 32'(fwd_ref(Rs1E)));
        chk("ForwardBE", 32'(fbe_p[1:0]), 32'(fwd_ref(Rs2E)));
        chk("ForwardAE_b", 32'(fae_p[3:2]), 32'(fwd_ref(Rs1E)));
        chk("ForwardBE_b", 32'(fbe_p[3:2]), 32'(fwd_ref(Rs2E)));
    endtask

    // Model: k counts how many cycles the current access has already stalled (0 = none pending).
    task automatic tick_adv();
        logic lw, ms;
        @(posedge clk);
        lw = ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                k[i] = 0; err[i] = 0; cnt[i] = 0;
            end else begin
                ms = !mem_ready && ((k[i] == 0) ? MemAccessM : (k[i] < tmo[i]));
                if ((lw || ms) && cnt[i] != 32'hFFFF_FFFF) cnt[i] = cnt[i] + 1;
                err[i] = 0;
                if (k[i] > 0) begin
                    if (mem_ready) k[i] = 0;
                    else if (k[i] == tmo[i]) begin k[i] = 0; err[i] = 1; end
                    else k[i] = k[i] + 1;
                end else if (MemAccessM && !mem_ready) begin
                    k[i] = 1;
                end
            end
        end
        #1;
    endtask

    task automatic step();
        tick_check();
        tick_adv();
    endtask

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
        MemAccessM = 0; mem_ready = 1;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs();
        step(); step();
        rst = 0;
    endtask

    task automatic set_mem(input logic acc, input logic rdy);
        MemAccessM = acc; mem_ready = rdy;
    endtask

    initial begin
        logic [31:0] c0;
        tmo[0] = 255; tmo[1] = 3;
        for (int i = 0; i < 2; i++) begin k[i] = 0; err[i] = 0; cnt[i] = 0; end

        //           rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rsrc pc  stl fd fe fae fbe
        tbl[0]  = '{ 5,   0,   0,   0,   5,  0,  0,  0,  0,  1,   0,  1,  0, 1, 0,  0 };
        tbl[1]  = '{ 0,   0,   3,   7,   0,  3,  3,  1,  1,  0,   0,  0,  0, 0, 2,  0 };
        tbl[2]  = '{ 0,   0,   0,   0,   0,  0,  0,  1,  1,  0,   0,  0,  0, 0, 0,  0 };
        tbl[3]  = '{ 0,   0,   4,   4,   0,  9,  4,  1,  1,  0,   0,  0,  0, 0, 1,  1 };
        tbl[4]  = '{ 0,   0,   2,   6,   0,  6,  6,  0,  1,  0,   0,  0,  0, 0, 0,  1 };
        tbl[5]  = '{ 0,   0,   0,   0,   0,  0,  0,  0,  0,  1,   0,  0,  0, 0, 0,  0 };
        tbl[6]  = '{ 1,   12,  0,   0,   12, 0,  0,  0,  0,  1,   0,  1,  0, 1, 0,  0 };
        tbl[7]  = '{ 1,   12,  0,   0,   12, 0,  0,  0,  0,  2,   0,  0,  0, 0, 0,  0 };
        tbl[8]  = '{ 0,   0,   0,   0,   0,  0,  0,  0,  0,  0,   1,  0,  1, 1, 0,  0 };
        tbl[9]  = '{ 8,   0,   0,   0,   8,  0,  0,  0,  0,  1,   1,  1,  1, 1, 0,  0 };
        tbl[10] = '{ 0,   0,   31,  31,  0,  31, 31, 1,  1,  0,   0,  0,  0, 0, 2,  2 };

        do_reset();

        for (int v = 0; v < 11; v++) begin
            Rs1D = tbl[v].rs1d; Rs2D = tbl[v].rs2d; Rs1E = tbl[v].rs1e; Rs2E = tbl[v].rs2e;
            RdE = tbl[v].rde; RdM = tbl[v].rdm; RdW = tbl[v].rdw;
            RegWriteM = tbl[v].rwm; RegWriteW = tbl[v].rww;
            ResultSrcE = tbl[v].rsrc; PCSrcE = tbl[v].pc;
            set_mem(0, 1);
            c0 = cnt[0];
            tick_check();
            chk($sformatf("tbl%0d.StallF", v), 32'(stall_f[0]), 32'(tbl[v].x_stall));
            chk($sformatf("tbl%0d.FlushD", v), 32'(flush_d[0]), 32'(tbl[v].x_fd));
            chk($sformatf("tbl%0d.FlushE", v), 32'(flush_e[0]), 32'(tbl[v].x_fe));
            chk($sformatf("tbl%0d.ForwardAE", v), 32'(fae_p[1:0]), 32'(tbl[v].x_fae));
            chk($sformatf("tbl%0d.ForwardBE", v), 32'(fbe_p[1:0]), 32'(tbl[v].x_fbe));
            tick_adv();
            idle_inputs();
            tick_check();
            chk($sformatf("tbl%0d.stall_cnt", v), cnt_p[31:0], c0 + 32'(tbl[v].x_stall));
            tick_adv();
        end

        // Memory wait of four cycles on the default instance.
        do_reset();
        c0 = cnt[0];
        for (int c = 0; c < 4; c++) begin
            set_mem(1, 0);
            tick_check();
            chk("wait.StallF", 32'(stall_f[0]), 1);
            chk("wait.StallM", 32'(stall_m[0]), 1);
            chk("wait.FlushW", 32'(flush_w[0]), 1);
            tick_adv();
        end
        set_mem(1, 1);
        tick_check();
        chk("wait_done.StallE", 32'(stall_e[0]), 0);
        chk("wait_done.FlushW", 32'(flush_w[0]), 0);
        tick_adv();
        set_mem(0, 0);
        tick_check();
        chk("wait_idle.StallF", 32'(stall_f[0]), 0);
        chk("wait.stall_cnt", cnt_p[31:0], c0 + 4);
        tick_adv();

        // Timeout on the TIMEOUT=3 instance.
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            set_mem(c <= 4, 0);
            tick_check();
            chk($sformatf("tmo%0d.StallF_b", c), 32'(stall_f[1]), 32'(c <= 3));
            chk($sformatf("tmo%0d.mem_err_b", c), 32'(merr[1]), 32'(c == 5));
            tick_adv();
        end
        set_mem(0, 1);
        tick_check();
        chk("tmo6.mem_err_b", 32'(merr[1]), 0);
        tick_adv();

        // Branch held in E while memory stalls.
        do_reset();
        PCSrcE = 1;
        for (int c = 0; c < 3; c++) begin
            set_mem(1, 0);
            tick_check();
            chk("br_hold.FlushD", 32'(flush_d[0]), 0);
            chk("br_hold.FlushE", 32'(flush_e[0]), 0);
            tick_adv();
        end
        set_mem(1, 1);
        tick_check();
        chk("br_rel.FlushD", 32'(flush_d[0]), 1);
        chk("br_rel.FlushE", 32'(flush_e[0]), 1);
        tick_adv();
        PCSrcE = 0;

        // Back-to-back access restarts the wait counter (TIMEOUT=3 instance).
        do_reset();
        set_mem(1, 0); step(); step();
        set_mem(1, 1); step();
        for (int c = 1; c <= 4; c++) begin
            set_mem(1, 0);
            tick_check();
            chk($sformatf("b2b%0d.StallF_b", c), 32'(stall_f[1]), 32'(c <= 3));
            tick_adv();
        end
        set_mem(0, 1); step();

        // Reset during WAIT cycle 2.
        do_reset();
        set_mem(1, 0); step(); step();
        rst = 1;
        tick_check();
        chk("rstw.StallF", 32'(stall_f[0]), 0);
        chk("rstw.StallE", 32'(stall_e[0]), 0);
        tick_adv();
        rst = 0; set_mem(0, 0);
        tick_check();
        chk("rstw.idle_StallF", 32'(stall_f[0]), 0);
        chk("rstw.stall_cnt", cnt_p[31:0], 0);
        chk("rstw.mem_err", 32'(merr[0]), 0);
        tick_adv();

        // Reset in the very cycle a timeout would fire must suppress mem_err.
        do_reset();
        set_mem(1, 0); step(); step(); step();
        rst = 1; step();
        rst = 0; set_mem(0, 1);
        tick_check();
        chk("rst_tmo.mem_err_b", 32'(merr[1]), 0);
        tick_adv();

        // Randomised run against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE = 5'($urandom_range(0, 3));  RdM = 5'($urandom_range(0, 3));
            RdW = 5'($urandom_range(0, 3));
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            ResultSrcE = 2'($urandom_range(0, 3)); PCSrcE = 1'($urandom_range(0, 1));
            MemAccessM = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, max WAIT cycles before memory-timeout abort (1..255).
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- Rs1D, Rs2D  in  5 each  decode-stage source registers.
- Rs1E, Rs2E, RdE  in  5 each  execute-stage register fields.
- RdM, RdW  in  5 each  memory / writeback destination registers.
- RegWriteM, RegWriteW  in  1 each  destination write enables in M / W.
- ResultSrcE  in  2  execute-stage result select; 2'b01 = load.
- PCSrcE  in  1  branch taken / jump in E.
- MemAccessM  in  1  load or store in M.
- mem_ready  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM registers.
- FlushD, FlushE, FlushW  out  1 each  clear IF-ID / ID-EX / MEM-WB registers.
- ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 RD1E/RD2E, 01 WB result, 10 M ALU result.
- mem_err  out  1  one-cycle timeout pulse.
- stall_cnt  out  32  saturating count of StallF-asserted cycles.

Function
REQ-003 SHALL implement FSM states IDLE and WAIT; plus an 8-bit wait counter wcnt.
REQ-004 In IDLE: MemAccessM=1 and mem_ready=0 -> WAIT, wcnt<=1. Otherwise stay IDLE.
REQ-005 In WAIT, mem_ready=1 -> IDLE; wcnt is don't-care.
REQ-006 In WAIT, mem_ready=0 and wcnt==TIMEOUT -> IDLE, mem_err<=1 on the next cycle.
REQ-007 In WAIT, otherwise stay in WAIT and increment wcnt.
REQ-008 SHALL compute memStall as (IDLE & MemAccessM & !mem_ready) | (WAIT & !mem_ready & wcnt!=TIMEOUT); combinational, 0-cycle latency.
REQ-009 SHALL compute lwStall as (ResultSrcE==2'b01) & (RdE!=0) & ((RdE==Rs1D)|(RdE==Rs2D)).
REQ-010 SHALL drive stall outputs: StallF=StallD=lwStall|memStall; StallE=StallM=memStall.
REQ-011 SHALL drive flush outputs:
- FlushD = PCSrcE & !memStall.
- FlushE = (lwStall|PCSrcE) & !memStall.
- FlushW = memStall.
REQ-012 Memory stall SHALL take priority: no D/E flush while memStall=1. A branch pending in E is held frozen and its flush is applied in the first cycle after memStall drops.
REQ-013 ForwardAE SHALL select its source in priority order:
- 10 if RegWriteM & RdM!=0 & RdM==Rs1E;
- else 01 if RegWriteW & RdW!=0 & RdW==Rs1E;
- else 00.
REQ-014 ForwardBE SHALL use the same priority rule as REQ-013 with Rs2E in place of Rs1E.
REQ-015 Forwarding SHALL never select register x0.
REQ-016 mem_err SHALL be registered and high for exactly one cycle per timeout.
REQ-017 stall_cnt SHALL increment by 1 on each cycle StallF=1 and saturate at 32'hFFFF_FFFF.
REQ-018 Simultaneous lwStall and PCSrcE (no memStall): StallF=StallD=1, FlushD=FlushE=1.
REQ-019 A back-to-back MemAccessM immediately after returning from WAIT SHALL be treated as a new access: re-enter WAIT with wcnt restarted.

Reset
REQ-020 With rst=1 at a rising edge: state<=IDLE, wcnt<=0, mem_err<=0, stall_cnt<=0.
REQ-021 While rst=1, all stall/flush outputs SHALL be 0, and stall_cnt SHALL not increment.
REQ-022 Reset asserted in WAIT SHALL abort the access with no mem_err pulse.

Verification
REQ-023 Load-use: ResultSrcE=01, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1, FlushD=0; stall_cnt +1.
REQ-024 Forwarding: RdM=RdW=3, RegWriteM=RegWriteW=1, Rs1E=3 -> ForwardAE=10. RdM=0, RegWriteM=1, Rs2E=0 -> ForwardBE=00.
REQ-025 Memory wait: MemAccessM=1, mem_ready low for 4 cycles then high -> Stall{F,D,E,M}=FlushW=1 for 4 cycles, then all 0; state back in IDLE; stall_cnt +4.
REQ-026 Timeout with TIMEOUT=3: mem_ready held 0 -> stall for 3 cycles, stall drops, mem_err=1 exactly one cycle later, state IDLE.
REQ-027 Branch during memory stall: PCSrcE=1 held while memStall=1 -> FlushD=FlushE=0 throughout; both go 1 in the cycle mem_ready=1.
REQ-028 Reset mid-WAIT: rst=1 on cycle 2 of WAIT -> next cycle state IDLE, stall_cnt=0, mem_err=0, all stall outputs 0.
